// File: rtl/bsg_pkg.sv
// Shared types and constants for the BSG transmit path: FSM states, line levels,
// register map addresses and BSG_CONTROL bit positions.
package bsg_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, STOP, HOLD} state_t;

   localparam int FRAME_BITS = 18;

   localparam logic START_LVL = 1'b0;
   localparam logic STOP_LVL  = 1'b1;
   localparam logic IDLE_LVL  = 1'b1;

   localparam logic [7:0] ADDR_CTRL  = 8'h10;
   localparam logic [7:0] ADDR_DATA1 = 8'h11;
   localparam logic [7:0] ADDR_DATA2 = 8'h12;

   localparam int TXEN    = 0;
   localparam int INTMSK  = 1;
   localparam int INTFLAG = 2;
   localparam int STATUS  = 3;

   function automatic logic [7:0] rev8(input logic [7:0] b);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = b[7-i];
      return r;
   endfunction

endpackage

// File: rtl/bsg_bit_timer.sv
// Bit-period divider: tick on the last cycle of each BIT_DIV-cycle bit, pre_tick one cycle earlier.
// Counter is held at zero while clear is high, so the first bit after clear is full length.
module bsg_bit_timer #(
   parameter int BIT_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick,
   output logic pre_tick
);

   localparam int W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
   localparam logic [W-1:0] LAST = W'(BIT_DIV - 1);
   localparam logic [W-1:0] PRE  = W'(BIT_DIV - 2);

   logic [W-1:0] div_cnt;

   assign tick     = (div_cnt == LAST);
   // With a one-cycle bit there is no cycle before the terminal one.
   assign pre_tick = (BIT_DIV > 1) && (div_cnt == PRE);

   always_ff @(posedge clk) begin
      if (rst || clear || tick) div_cnt <= '0;
      else                      div_cnt <= div_cnt + W'(1);
   end

endmodule

// File: rtl/bsg_tx_sequencer.sv
// Sends one 18-bit frame (start, data1, data2, stop) per tx_enable assertion; outputs are
// registered, first start-bit cycle follows the enabling edge, frame lasts 18*BIT_DIV cycles.
module bsg_tx_sequencer
   import bsg_pkg::*;
#(
   parameter int BIT_DIV   = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_enable,
   input  logic       int_mask,
   input  logic       int_clear,
   input  logic [7:0] data1,
   input  logic [7:0] data2,
   output logic       status,
   output logic       int_flag,
   output logic       tx_done,
   output logic       serial_out
);

   localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS - 2);
   localparam logic [4:0] SAT_BIT  = 5'(FRAME_BITS - 1);

   state_t      state;
   logic [4:0]  bit_cnt;
   logic [15:0] shadow;
   logic        tick;
   logic        pre_tick;
   logic        timer_clear;

   assign timer_clear = (state == IDLE) || (state == HOLD);

   bsg_bit_timer #(.BIT_DIV(BIT_DIV)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .clear    (timer_clear),
      .tick     (tick),
      .pre_tick (pre_tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         shadow     <= '0;
         status     <= 1'b0;
         int_flag   <= 1'b0;
         tx_done    <= 1'b0;
         serial_out <= IDLE_LVL;
      end else begin
         tx_done <= 1'b0;
         if (tx_done && int_mask) int_flag <= 1'b1;
         else if (int_clear)      int_flag <= 1'b0;

         case (state)
            IDLE: begin
               if (tx_enable) begin
                  state      <= SHIFT;
                  bit_cnt    <= '0;
                  // Bytes are pre-reversed for LSB-first so the shifter always drains bit 15.
                  shadow     <= MSB_FIRST ? {data1, data2} : {rev8(data1), rev8(data2)};
                  status     <= 1'b1;
                  serial_out <= START_LVL;
               end
            end
            SHIFT: begin
               if (!tx_enable) begin
                  state      <= IDLE;
                  status     <= 1'b0;
                  serial_out <= IDLE_LVL;
               end else if (tick) begin
                  if (bit_cnt == LAST_BIT) begin
                     state      <= STOP;
                     bit_cnt    <= SAT_BIT;
                     serial_out <= STOP_LVL;
                     tx_done    <= (BIT_DIV == 1);
                  end else begin
                     bit_cnt    <= bit_cnt + 5'd1;
                     serial_out <= shadow[15];
                     shadow     <= {shadow[14:0], 1'b0};
                  end
               end
            end
            STOP: begin
               if (!tx_enable) begin
                  state      <= IDLE;
                  status     <= 1'b0;
                  serial_out <= IDLE_LVL;
               end else if (tick) begin
                  state  <= HOLD;
                  status <= 1'b0;
               end else if (pre_tick) begin
                  // Registered pulse must land on the final stop cycle, so arm it one cycle early.
                  tx_done <= 1'b1;
               end
            end
            HOLD: begin
               if (!tx_enable) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bsg_tx_sequencer.sv
// Randomized scoreboard bench for bsg_tx_sequencer: the driver queues the expected frame
// for each transaction, a negedge monitor captures each status-high window and compares.
module tb_bsg_tx_sequencer;

   localparam int BD        = 4;
   localparam bit MSBF      = 1'b1;
   localparam int FRAME_CYC = 18 * BD;

   typedef struct {
      logic [17:0] bits;
      int          len;
      int          done_pos;
      logic        flag;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst, tx_enable, int_mask, int_clear;
   logic [7:0] data1, data2;
   logic       status, int_flag, tx_done, serial_out;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   idle_bad = 0;
   logic flag_m;
   bit   in_frame = 1'b0;
   logic act_w[$];
   int   done_pos;

   always #5 clk = ~clk;

   bsg_tx_sequencer #(.BIT_DIV(BD), .MSB_FIRST(MSBF)) dut (
      .clk        (clk),
      .rst        (rst),
      .tx_enable  (tx_enable),
      .int_mask   (int_mask),
      .int_clear  (int_clear),
      .data1      (data1),
      .data2      (data2),
      .status     (status),
      .int_flag   (int_flag),
      .tx_done    (tx_done),
      .serial_out (serial_out)
   );

   task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   // Line-order bit list: index 0 is the start bit, 17 the stop bit.
   function automatic logic [17:0] model_bits(input logic [7:0] d1, input logic [7:0] d2);
      logic [17:0] b;
      b[0]  = 1'b0;
      b[17] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         b[1+i] = MSBF ? d1[7-i] : d1[i];
         b[9+i] = MSBF ? d2[7-i] : d2[i];
      end
      return b;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_pulse();
      int_clear = 1'b1;
      step();
      int_clear = 1'b0;
      flag_m    = 1'b0;
      step();
   endtask

   // kind: 0 = full frame, 1 = tx_enable dropped at cycle N+k, 2 = reset at cycle N+k
   task automatic run_frame(input logic [7:0] d1, input logic [7:0] d2, input logic mask,
                            input int kind, input int k, input logic clr_at_done,
                            input int hold, input logic [7:0] new_d1);
      exp_t e;
      int   n;
      int_mask   = mask;
      data1      = d1;
      data2      = d2;
      e.bits     = model_bits(d1, d2);
      if (kind == 0) begin
         e.len      = FRAME_CYC;
         e.done_pos = FRAME_CYC - 1;
         e.flag     = mask ? 1'b1 : (clr_at_done ? 1'b0 : flag_m);
      end else begin
         e.len      = k;
         e.done_pos = -1;
         e.flag     = (kind == 2) ? 1'b0 : flag_m;
      end
      flag_m = e.flag;
      sb.push_back(e);
      tx_enable = 1'b1;
      step();
      n = (kind == 0) ? FRAME_CYC : k;
      for (int c = 1; c <= n; c++) begin
         if (c == 10) begin
            data1 = new_d1;
            data2 = 8'($urandom);
         end
         if (kind == 0 && c == FRAME_CYC && clr_at_done) int_clear = 1'b1;
         if (kind == 1 && c == k) tx_enable = 1'b0;
         if (kind == 2 && c == k) begin
            rst       = 1'b1;
            tx_enable = 1'b0;
         end
         step();
      end
      int_clear = 1'b0;
      rst       = 1'b0;
      if (kind == 0) begin
         repeat (hold) step();
         tx_enable = 1'b0;
      end
      step();
      step();
   endtask

   // Monitor: collects each status-high window and checks it against the queued expectation.
   initial begin
      exp_t e;
      int   err;
      logic expbit;
      @(negedge clk);
      @(negedge clk);
      chk("reset_state", {status, int_flag, tx_done, serial_out}, 4'b0001);
      forever begin
         @(negedge clk);
         if (status === 1'b1) begin
            if (!in_frame) begin
               act_w.delete();
               done_pos = -1;
               in_frame = 1'b1;
            end
            if (tx_done === 1'b1) done_pos = (done_pos == -1) ? act_w.size() : -2;
            act_w.push_back(serial_out);
         end else begin
            if (rst !== 1'b1 && (serial_out !== 1'b1 || tx_done !== 1'b0)) idle_bad++;
            if (in_frame) begin
               in_frame = 1'b0;
               if (sb.size() == 0) begin
                  chk("unexpected_frame", act_w.size(), 0);
               end else begin
                  e = sb.pop_front();
                  chk("frame_len", act_w.size(), e.len);
                  err = 0;
                  for (int c = 0; c < act_w.size(); c++) begin
                     expbit = (c / BD < 18) ? e.bits[c / BD] : 1'b1;
                     if (act_w[c] !== expbit) err++;
                  end
                  chk("wave_bad_cycles", err, 0);
                  chk("tx_done_pos", done_pos, e.done_pos);
                  chk("post_frame_int_flag", int_flag, e.flag);
                  chk("post_frame_serial_out", serial_out, 1);
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      rst = 1'b1; tx_enable = 1'b0; int_mask = 1'b0; int_clear = 1'b0;
      data1 = '0; data2 = '0; flag_m = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      step();

      run_frame(8'hA5, 8'h3C, 1'b0, 0, 0, 1'b0, 3, 8'hFF);  // basic frame, data1 rewritten mid-frame
      run_frame(8'hA5, 8'h3C, 1'b1, 0, 0, 1'b0, 0, 8'h00);  // interrupt sets
      clear_pulse();
      run_frame(8'h5A, 8'hC3, 1'b0, 0, 0, 1'b0, 1, 8'h11);  // flag stays cleared with mask off
      run_frame(8'h01, 8'h80, 1'b1, 0, 0, 1'b1, 0, 8'h22);  // clear coincides with tx_done
      run_frame(8'hFF, 8'h00, 1'b0, 0, 0, 1'b0, 2, 8'h33);  // mask off keeps set flag
      run_frame(8'hA5, 8'h3C, 1'b1, 1, 20, 1'b0, 0, 8'h44); // abort at N+20
      run_frame(8'hA5, 8'h3C, 1'b0, 0, 0, 1'b0, 0, 8'h55); // fresh frame after abort
      run_frame(8'h96, 8'h69, 1'b1, 2, 30, 1'b0, 0, 8'h66); // reset at N+30
      run_frame(8'h3C, 8'hA5, 1'b1, 0, 0, 1'b0, 10, 8'h77); // long HOLD with tx_enable high

      for (int i = 0; i < 25; i++) begin
         if ($urandom_range(0, 2) == 0) clear_pulse();
         r = $urandom_range(0, 9);
         if (r <= 5)
            run_frame(8'($urandom), 8'($urandom), 1'($urandom), 0, 0, 1'($urandom),
                      $urandom_range(0, 6), 8'($urandom));
         else if (r <= 8)
            run_frame(8'($urandom), 8'($urandom), 1'($urandom), 1, $urandom_range(1, FRAME_CYC - 1),
                      1'b0, 0, 8'($urandom));
         else
            run_frame(8'($urandom), 8'($urandom), 1'($urandom), 2, $urandom_range(1, FRAME_CYC - 1),
                      1'b0, 0, 8'($urandom));
      end

      repeat (5) step();
      chk("scoreboard_drained", sb.size(), 0);
      chk("idle_level_errors", idle_bad, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bsg_tx_sequencer.md
Name: bsg_tx_sequencer

Overview:
- Transmit controller for the BSG peripheral. It sequences one serial frame built from the data1/data2 registers when TXENABLE is set.
- It drives the STATUS bit back into BSG_CONTROL, which blocks register writes while busy.
- It raises the INTFLAG on completion when INTMSK is set.
- It sits between the bus register block (control/data registers at 8'h10–8'h12) and the serial output pin.

Parameters:
- BIT_DIV, 4, clock cycles per serial bit (legal range 1..255).
- MSB_FIRST, 1, 1 = each byte is shifted MSB first; 0 = LSB first.

Ports:
- clk, input, 1, system clock, rising edge.
- rst, input, 1, synchronous reset, active-high.
- tx_enable, input, 1, BSG_CONTROL[0] TXENABLE, level.
- int_mask, input, 1, BSG_CONTROL[1] INTMSK.
- int_clear, input, 1, one-cycle pulse: the bus wrote 0 to INTFLAG.
- data1, input, 8, first payload byte.
- data2, input, 8, second payload byte.
- status, output, 1, drives BSG_CONTROL[3] STATUS; 1 = frame in progress.
- int_flag, output, 1, drives BSG_CONTROL[2] INTFLAG; sticky.
- tx_done, output, 1, one-cycle pulse at normal frame completion.
- serial_out, output, 1, serial line; idle level is 1.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; status=0; int_flag=0; tx_done=0; serial_out=1.
  - All counters and shadow registers are cleared.
  - Reset has priority over every other input, including mid-frame.
- Frame format: 18 bits, each held exactly BIT_DIV cycles.
  - One start bit (0).
  - data1 (8 bits), then data2 (8 bits), bit order per MSB_FIRST.
  - One stop bit (1).
  - Total frame length is 18*BIT_DIV cycles.
- FSM states: IDLE, SHIFT, STOP, HOLD.
  - IDLE: status=0, serial_out=1. If tx_enable=1 at edge N:
    - capture data1/data2 into a 16-bit shadow register;
    - go to SHIFT with bit_cnt=0, div_cnt=0;
    - from cycle N+1: status=1, serial_out=0 (start bit).
  - SHIFT: serial_out = current bit (bit_cnt 0 = start, bits 1..16 = payload).
    - div_cnt counts 0..BIT_DIV-1; on terminal count, bit_cnt increments and div_cnt wraps to 0.
    - After bit 16 completes, go to STOP.
  - STOP: serial_out=1 for BIT_DIV cycles. On the final stop cycle:
    - tx_done=1 for that single cycle;
    - go to HOLD;
    - int_flag is set on the next edge if int_mask=1.
  - HOLD: status=0, serial_out=1. Return to IDLE only when tx_enable=0, so no frame repeats while tx_enable stays high.
- Data changes during a frame: writes to data1/data2 after capture are ignored; only the shadow register is shifted.
- Abort: tx_enable=0 sampled in SHIFT or STOP →
  - IDLE on the next cycle, serial_out=1, status=0;
  - no tx_done, int_flag unchanged.
- int_flag:
  - set when (tx_done & int_mask);
  - cleared by int_clear;
  - set wins if both occur in the same cycle;
  - int_mask=0 never clears an already-set flag.
- Widths:
  - div_cnt is $clog2(BIT_DIV) bits, minimum 1; BIT_DIV=1 means every bit lasts one cycle.
  - bit_cnt is 5 bits and saturates at 17.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package bsg_pkg holds:
  - the state enum (IDLE, SHIFT, STOP, HOLD);
  - FRAME_BITS=18;
  - START_LVL=0, STOP_LVL=1, IDLE_LVL=1;
  - register address constants ADDR_CTRL=8'h10, ADDR_DATA1=8'h11, ADDR_DATA2=8'h12;
  - control bit indices TXEN=0, INTMSK=1, INTFLAG=2, STATUS=3.
- One natural sub-module, bsg_bit_timer: the BIT_DIV divider. Inputs are clk, rst and clear; output is a tick on terminal count. The FSM and shift register stay in the top level.

Test Plan:
- Basic frame: BIT_DIV=4, MSB_FIRST=1, data1=8'hA5, data2=8'h3C, tx_enable=1 at edge N →
  - serial_out sampled every 4 cycles reads 0,1010_0101,0011_1100,1;
  - status=1 for cycles N+1..N+72;
  - tx_done pulses at cycle N+72;
  - status=0 at N+73.
- Interrupt: same frame with int_mask=1 → int_flag=1 from N+73 and remains set; an int_clear pulse clears it. With int_mask=0, int_flag stays 0.
- Simultaneous set/clear: int_clear asserted in the same cycle as tx_done with int_mask=1 → int_flag=1.
- Abort: tx_enable dropped at cycle N+20 →
  - serial_out=1 and status=0 from N+21;
  - no tx_done, int_flag unchanged;
  - re-asserting tx_enable starts a fresh frame with a start bit.
- Shadow capture and HOLD:
  - data1 changed to 8'hFF at N+10 → transmitted payload still 8'hA5;
  - tx_enable held high after completion → no second start bit until tx_enable goes low then high.
- Reset mid-frame: rst=1 at N+30 → next cycle serial_out=1, status=0, int_flag=0, tx_done=0; FSM is in IDLE.
